// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Brief   : Shared 4x4 game constants and encodings. WIN_DIAGONAL_EN adds the
//           two diagonals to the scanned line set.
// Revision: 1.0
// ============================================================================
package game_pkg;

  localparam int BOARD_DIM   = 4;
  localparam int BOARD_CELLS = 16;

`ifdef WIN_DIAGONAL_EN
  localparam int NUM_LINES = 10;
`else
  localparam int NUM_LINES = 8;
`endif

  typedef enum logic [1:0] {
    GAME_INIT = 2'd0,
    P1_TURN   = 2'd1,
    P2_TURN   = 2'd2,
    END_GAME  = 2'd3
  } game_state_e;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  localparam logic [1:0] CHK_IDLE = 2'd0;
  localparam logic [1:0] CHK_SCAN = 2'd1;
  localparam logic [1:0] CHK_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/board_win_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : board_win_checker_if
// Brief   : Request/result bundle between the game FSM (master) and checker.
// Revision: 1.0
// ============================================================================
interface board_win_checker_if;
  import game_pkg::*;

  logic                   start;
  logic [BOARD_CELLS-1:0] gameboard;
  logic [BOARD_CELLS-1:0] players_cells;
  logic                   busy;
  logic                   done;
  logic                   winner_valid;
  logic                   winner;
  logic                   draw;
  logic [BOARD_CELLS-1:0] win_mask;

  modport master (
    output start, gameboard, players_cells,
    input  busy, done, winner_valid, winner, draw, win_mask
  );

  modport slave (
    input  start, gameboard, players_cells,
    output busy, done, winner_valid, winner, draw, win_mask
  );
endinterface
`default_nettype wire

// File: rtl/board_win_checker_win_line_rom.sv
`default_nettype none
// ============================================================================
// Module  : win_line_rom
// Brief   : Line index to cell mask. Diagonals present only with WIN_DIAGONAL_EN.
// Revision: 1.0
// ============================================================================
module win_line_rom
  import game_pkg::*;
#(
  parameter int NUM_LINES = game_pkg::NUM_LINES
) (
  input  wire logic [3:0]  line_idx,
  output logic      [15:0] mask
);

  always_comb begin
    mask = 16'h0000;
    if ({28'd0, line_idx} < 32'(NUM_LINES)) begin
      case (line_idx)
        4'd0, 4'd1, 4'd2, 4'd3: mask = 16'h000F << {line_idx[1:0], 2'b00};
        4'd4, 4'd5, 4'd6, 4'd7: mask = 16'h1111 << line_idx[1:0];
`ifdef WIN_DIAGONAL_EN
        4'd8:                   mask = 16'h8421;
        4'd9:                   mask = 16'h1248;
`endif
        default:                mask = 16'h0000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_win_checker.sv
`default_nettype none
// ============================================================================
// Module  : board_win_checker
// Brief   : Sequential one-line-per-clock win/draw scan of a board snapshot.
//           WIN_DIAGONAL_EN enables the two diagonal lines.
// Revision: 1.0
// ============================================================================
module board_win_checker
  import game_pkg::*;
#(
  parameter int BOARD_DIM = game_pkg::BOARD_DIM,
  parameter int NUM_LINES = game_pkg::NUM_LINES
) (
  input  wire logic          clk,
  input  wire logic          reset,
  board_win_checker_if.slave bus
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;

  logic [1:0]       state_q, state_d;
  logic [CELLS-1:0] snap_gb_q, snap_gb_d;
  logic [CELLS-1:0] snap_pc_q, snap_pc_d;
  logic [3:0]       line_idx_q, line_idx_d;
  logic             winner_valid_q, winner_valid_d;
  logic             winner_q, winner_d;
  logic             draw_q, draw_d;
  logic [CELLS-1:0] win_mask_q, win_mask_d;

  logic [CELLS-1:0] line_mask;
  logic             line_win;
  logic             last_line;

  win_line_rom #(
    .NUM_LINES (NUM_LINES)
  ) u_rom (
    .line_idx (line_idx_q),
    .mask     (line_mask)
  );

  // Full line owned by one player: owner bits all-0 or all-1 under the mask.
  assign line_win  = (line_mask != '0)
                  && ((snap_gb_q & line_mask) == line_mask)
                  && (((snap_pc_q & line_mask) == '0)
                   || ((snap_pc_q & line_mask) == line_mask));
  assign last_line = (line_idx_q == 4'(NUM_LINES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= CHK_IDLE;
      snap_gb_q      <= '0;
      snap_pc_q      <= '0;
      line_idx_q     <= '0;
      winner_valid_q <= 1'b0;
      winner_q       <= 1'b0;
      draw_q         <= 1'b0;
      win_mask_q     <= '0;
    end else begin
      state_q        <= state_d;
      snap_gb_q      <= snap_gb_d;
      snap_pc_q      <= snap_pc_d;
      line_idx_q     <= line_idx_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
      draw_q         <= draw_d;
      win_mask_q     <= win_mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_IDLE: if (bus.start) state_d = CHK_SCAN;
      CHK_SCAN: if (line_win || last_line) state_d = CHK_DONE;
      CHK_DONE: state_d = CHK_IDLE;
      default:  state_d = CHK_IDLE;
    endcase
  end

  always_comb begin
    snap_gb_d      = snap_gb_q;
    snap_pc_d      = snap_pc_q;
    line_idx_d     = line_idx_q;
    winner_valid_d = winner_valid_q;
    winner_d       = winner_q;
    draw_d         = draw_q;
    win_mask_d     = win_mask_q;
    if (state_q == CHK_IDLE && bus.start) begin
      snap_gb_d      = bus.gameboard;
      snap_pc_d      = bus.players_cells;
      line_idx_d     = '0;
      winner_valid_d = 1'b0;
      winner_d       = 1'b0;
      draw_d         = 1'b0;
      win_mask_d     = '0;
    end else if (state_q == CHK_SCAN) begin
      if (line_win) begin
        winner_valid_d = 1'b1;
        winner_d       = |(snap_pc_q & line_mask);
        win_mask_d     = line_mask;
      end else if (last_line) begin
        draw_d = &snap_gb_q;
      end else begin
        line_idx_d = line_idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    bus.busy         = (state_q == CHK_SCAN);
    bus.done         = (state_q == CHK_DONE);
    bus.winner_valid = winner_valid_q;
    bus.winner       = winner_q;
    bus.draw         = draw_q;
    bus.win_mask     = win_mask_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_board_win_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_board_win_checker
// Brief   : Directed self-checking bench for board_win_checker.
// Revision: 1.0
// ============================================================================
module tb_board_win_checker;

`ifdef WIN_DIAGONAL_EN
  localparam int NL = 10;
`else
  localparam int NL = 8;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  board_win_checker_if bif ();

  board_win_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle N+1 is the first negedge after the accepting edge N.
  task automatic run_scan(input string tag, input logic [15:0] gb, input logic [15:0] pc,
                          input int exp_lat, input logic exp_wv, input logic exp_w,
                          input logic exp_draw, input logic [15:0] exp_mask,
                          input bit repulse);
    int cnt;
    int ndone;
    @(negedge clk);
    bif.gameboard     = gb;
    bif.players_cells = pc;
    bif.start         = 1'b1;
    @(negedge clk);
    bif.start         = 1'b0;
    bif.gameboard     = ~gb;
    bif.players_cells = ~pc;
    cnt = 1;
    check({tag, "_busy"}, {31'd0, bif.busy}, 32'd1);
    check({tag, "_clr"}, {15'd0, bif.winner_valid, bif.win_mask}, 32'd0);
    while (!bif.done && cnt < 40) begin
      bif.start = (repulse && (cnt == 3 || cnt == 5));
      @(negedge clk);
      cnt++;
    end
    bif.start = 1'b0;
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_busy_at_done"}, {31'd0, bif.busy}, 32'd0);
    check({tag, "_res"}, {13'd0, bif.winner_valid, bif.winner, bif.draw, bif.win_mask},
          {13'd0, exp_wv, exp_w, exp_draw, exp_mask});
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bif.done) ndone++;
    end
    check({tag, "_single_done"}, ndone, 0);
    check({tag, "_hold"}, {13'd0, bif.winner_valid, bif.winner, bif.draw, bif.win_mask},
          {13'd0, exp_wv, exp_w, exp_draw, exp_mask});
  endtask

  initial begin
    int ndone;
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b1;
    bif.start         = 1'b0;
    bif.gameboard     = 16'h0;
    bif.players_cells = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outs", {11'd0, bif.busy, bif.done, bif.winner_valid, bif.winner,
                         bif.draw, bif.win_mask}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs", {30'd0, bif.busy, bif.done}, 32'd0);

    run_scan("row0_p1", 16'h000F, 16'h0000, 2, 1'b1, 1'b0, 1'b0, 16'h000F, 1'b0);

    // Abort a scan with reset three cycles after acceptance.
    @(negedge clk);
    bif.gameboard     = 16'h4444;
    bif.players_cells = 16'h4444;
    bif.start         = 1'b1;
    @(negedge clk);
    bif.start         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outs", {11'd0, bif.busy, bif.done, bif.winner_valid, bif.winner,
                         bif.draw, bif.win_mask}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bif.done) ndone++;
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bif.done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    run_scan("col2_p2", 16'h4444, 16'h4444, 8, 1'b1, 1'b1, 1'b0, 16'h4444, 1'b0);
`ifdef WIN_DIAGONAL_EN
    run_scan("anti_diag", 16'h1248, 16'h1248, 11, 1'b1, 1'b1, 1'b0, 16'h1248, 1'b0);
`else
    run_scan("anti_diag", 16'h1248, 16'h1248, 9, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
`endif
    run_scan("full_draw", 16'hFFFF, 16'hC3C3, NL + 1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    run_scan("mixed_row", 16'h000F, 16'h0007, NL + 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_scan("row3_p2", 16'hF000, 16'hF000, 5, 1'b1, 1'b1, 1'b0, 16'hF000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
